// File: rtl/tdc_frame_ctrl.sv
// tdc_frame_ctrl
//   Sequences a frame of TDC shots spaced a fixed number of clocks apart,
//   waits for the histogram unit to return a peak depth (or times out), and
//   presents the result on a valid/ready output.
//
// Ports
//   clk          logic clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   cfg_en       1 = run frames back-to-back, 0 = stop after current frame
//   cfg_period   shot interval in clocks (min 4), latched at frame start
//   cfg_batch    shots per frame (min 1), latched at frame start
//   tdc_busy     TDC still measuring; a shot due while busy is skipped
//   TDC_start    registered 2-cycle shot pulse
//   his_valid    histogram result valid (only honoured while collecting)
//   his_data     histogram peak depth
//   HIS_Oready   ready to the histogram unit
//   frame_data   frame result (15'h7FFF on timeout)
//   frame_valid  frame result valid
//   frame_ready  consumer ready
//   frame_err    frame result came from a timeout
//   skip_cnt     shots skipped in the current/last frame (saturating)
module tdc_frame_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_en,
   input  logic [19:0] cfg_period,
   input  logic [15:0] cfg_batch,
   input  logic        tdc_busy,
   output logic        TDC_start,
   input  logic        his_valid,
   input  logic [14:0] his_data,
   output logic        HIS_Oready,
   output logic [14:0] frame_data,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic        frame_err,
   output logic [15:0] skip_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIRE,
      S_WAIT,
      S_COLLECT,
      S_OUT
   } state_t;

   state_t      state, state_nxt;
   logic [19:0] eff_period;
   logic [19:0] pcnt;
   logic [15:0] eff_batch;
   logic [15:0] shot_cnt;
   logic [11:0] tcnt;
   logic        frame_start;
   logic        shot_end;
   logic        last_shot;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      shot_end    = (pcnt == eff_period - 20'd1);
      last_shot   = (shot_cnt + 16'd1 == eff_batch);
      HIS_Oready  = (state == S_COLLECT);
      frame_valid = (state == S_OUT);
      case (state)
         S_IDLE: begin
            if (cfg_en) begin
               frame_start = 1'b1;
               state_nxt   = S_FIRE;
            end
         end
         S_FIRE: begin
            if (pcnt == 20'd1) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (shot_end) state_nxt = last_shot ? S_COLLECT : S_FIRE;
         end
         S_COLLECT: begin
            if (his_valid || tcnt == '1) state_nxt = S_OUT;
         end
         S_OUT: begin
            if (frame_ready) begin
               if (cfg_en) begin
                  frame_start = 1'b1;
                  state_nxt   = S_FIRE;
               end else begin
                  state_nxt   = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         TDC_start  <= 1'b0;
         frame_data <= '0;
         frame_err  <= 1'b0;
         skip_cnt   <= '0;
         eff_period <= 20'd4;
         eff_batch  <= 16'd1;
         pcnt       <= '0;
         shot_cnt   <= '0;
         tcnt       <= '0;
      end else begin
         TDC_start <= 1'b0;
         if (frame_start) begin
            eff_period <= (cfg_period < 20'd4) ? 20'd4 : cfg_period;
            eff_batch  <= (cfg_batch == '0) ? 16'd1 : cfg_batch;
            shot_cnt   <= '0;
            skip_cnt   <= '0;
            pcnt       <= '0;
         end
         case (state)
            S_FIRE: begin
               pcnt <= pcnt + 20'd1;
               // Busy is judged once at shot cycle 0; cycle 1 just extends
               // whatever was decided so the pulse is exactly 2 wide.
               if (pcnt == '0) begin
                  if (tdc_busy) begin
                     if (skip_cnt != '1) skip_cnt <= skip_cnt + 16'd1;
                  end else begin
                     TDC_start <= 1'b1;
                  end
               end else begin
                  TDC_start <= TDC_start;
               end
            end
            S_WAIT: begin
               if (shot_end) begin
                  pcnt     <= '0;
                  shot_cnt <= shot_cnt + 16'd1;
                  tcnt     <= '0;
               end else begin
                  pcnt <= pcnt + 20'd1;
               end
            end
            S_COLLECT: begin
               tcnt <= tcnt + 12'd1;
               if (his_valid) begin
                  frame_data <= his_data;
                  frame_err  <= 1'b0;
               end else if (tcnt == '1) begin
                  frame_data <= '1;
                  frame_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tdc_frame_ctrl.sv
// tb_tdc_frame_ctrl
//   Table of single-frame scenarios plus hand-written sequences for
//   back-pressure, back-to-back frames with config change, and reset.
//   Cycle index c counts falling edges from the frame's first drive point;
//   a frame started at c=0 enters FIRE at c=1, pulses at c=2+k*P and
//   enters COLLECT at c=1+B*P.
module tb_tdc_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_en;
   logic [19:0] cfg_period;
   logic [15:0] cfg_batch;
   logic        tdc_busy;
   logic        TDC_start;
   logic        his_valid;
   logic [14:0] his_data;
   logic        HIS_Oready;
   logic [14:0] frame_data;
   logic        frame_valid;
   logic        frame_ready;
   logic        frame_err;
   logic [15:0] skip_cnt;

   int checks   = 0;
   int failures = 0;

   always #2 clk = ~clk;

   tdc_frame_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_en      (cfg_en),
      .cfg_period  (cfg_period),
      .cfg_batch   (cfg_batch),
      .tdc_busy    (tdc_busy),
      .TDC_start   (TDC_start),
      .his_valid   (his_valid),
      .his_data    (his_data),
      .HIS_Oready  (HIS_Oready),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_err   (frame_err),
      .skip_cnt    (skip_cnt)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int period;     // cfg_period applied
      int batch;      // cfg_batch applied
      int eff_p;      // hand-computed effective period
      int eff_b;      // hand-computed effective batch
      int mask;       // bit k: tdc_busy during shot slot k
      int delay;      // his_valid this many cycles after COLLECT entry, -1 = never
      int data;       // his_data
      int noise;      // 1: stray his_valid with junk data the cycle before COLLECT
      int exp_pulses;
      int exp_skip;
      int exp_data;
      int exp_err;
   } vec_t;

   vec_t tv[6];

   initial begin
      int P, B, E, fv_exp, k;
      int n_rise, high, bad, first_ho, first_fv, fv_cnt, cap_data, cap_err, cap_skip;
      int rise_at[4];
      logic prev, prev_ho;

      tv[0] = '{640, 3,   640, 3, 'b0000, 10, 'h1234, 0, 3, 0, 'h1234, 0};
      tv[1] = '{100, 4,   100, 4, 'b0010,  5, 'h0ABC, 1, 3, 1, 'h0ABC, 0};
      tv[2] = '{2,   0,     4, 1, 'b0000,  0, 'h5555, 0, 1, 0, 'h5555, 0};
      tv[3] = '{10,  2,    10, 2, 'b0000, -1, 'h0111, 0, 2, 0, 'h7FFF, 1};
      tv[4] = '{3,   3,     4, 3, 'b0111,  3, 'h0001, 0, 0, 3, 'h0001, 0};
      tv[5] = '{5,   2,     5, 2, 'b0001,  7, 'h4321, 0, 1, 1, 'h4321, 0};

      rst = 1'b1; cfg_en = 1'b0; cfg_period = '0; cfg_batch = '0;
      tdc_busy = 1'b0; his_valid = 1'b0; his_data = '0; frame_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {TDC_start, HIS_Oready, frame_valid, frame_err, frame_data, skip_cnt}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // ---------------- table-driven single frames ----------------
      for (int r = 0; r < 6; r++) begin
         P = tv[r].eff_p; B = tv[r].eff_b; E = 1 + B * P;
         fv_exp = (tv[r].delay < 0) ? E + 4096 : E + tv[r].delay + 1;
         n_rise = 0; high = 0; bad = 0; first_ho = -1; first_fv = -1; fv_cnt = 0;
         cap_data = 0; cap_err = 0; cap_skip = 0; prev = 1'b0;
         cfg_period = tv[r].period[19:0];
         cfg_batch  = tv[r].batch[15:0];
         for (int c = 0; c <= fv_exp + 10; c++) begin
            @(negedge clk);
            if (TDC_start && !prev) begin
               n_rise++;
               k = (c - 2) / P;
               if (c < 2 || (c - 2) % P != 0 || k >= B || ((tv[r].mask >> k) & 1) != 0) bad++;
            end
            prev = TDC_start;
            if (TDC_start) high++;
            if (HIS_Oready && first_ho < 0) first_ho = c;
            if (frame_valid) begin
               fv_cnt++;
               if (first_fv < 0) begin
                  first_fv = c; cap_data = int'(frame_data);
                  cap_err = int'(frame_err); cap_skip = int'(skip_cnt);
               end
            end
            cfg_en = (c == 0);
            if (c >= 1 && (c - 1) / P < B) tdc_busy = ((tv[r].mask >> ((c - 1) / P)) & 1) != 0;
            else                           tdc_busy = 1'b0;
            if (tv[r].delay >= 0 && c == E + tv[r].delay) begin
               his_valid = 1'b1; his_data = tv[r].data[14:0];
            end else if (tv[r].noise != 0 && c == E - 1) begin
               his_valid = 1'b1; his_data = 15'h7000;
            end else begin
               his_valid = 1'b0; his_data = '0;
            end
         end
         chk($sformatf("v%0d_pulses", r), n_rise, tv[r].exp_pulses);
         chk($sformatf("v%0d_pulse_width", r), high, 2 * tv[r].exp_pulses);
         chk($sformatf("v%0d_pulse_position", r), bad, 0);
         chk($sformatf("v%0d_collect_entry", r), first_ho, E);
         chk($sformatf("v%0d_frame_valid_cycle", r), first_fv, fv_exp);
         chk($sformatf("v%0d_frame_valid_count", r), fv_cnt, 1);
         chk($sformatf("v%0d_frame_data", r), cap_data, tv[r].exp_data);
         chk($sformatf("v%0d_frame_err", r), cap_err, tv[r].exp_err);
         chk($sformatf("v%0d_skip_cnt", r), cap_skip, tv[r].exp_skip);
      end

      // ------- back-to-back frames, mid-frame config change, cfg_en drop in WAIT -------
      // Frame 1: P=6, COLLECT at 7, his at 8, OUT at 9, handshake -> FIRE at 10.
      // Frame 2 uses period 20 latched at the handshake: pulse 11, COLLECT 30, OUT 32.
      cfg_period = 20'd6; cfg_batch = 16'd1;
      n_rise = 0; fv_cnt = 0; first_fv = -1; first_ho = -1; cap_data = 0; prev = 1'b0; prev_ho = 1'b0;
      foreach (rise_at[i]) rise_at[i] = -1;
      for (int c = 0; c <= 80; c++) begin
         @(negedge clk);
         if (TDC_start && !prev) begin
            if (n_rise < 4) rise_at[n_rise] = c;
            n_rise++;
         end
         prev = TDC_start;
         if (HIS_Oready && !prev_ho && c > 9 && first_ho < 0) first_ho = c;
         prev_ho = HIS_Oready;
         if (frame_valid) begin
            fv_cnt++;
            if (c > 9 && first_fv < 0) begin first_fv = c; cap_data = int'(frame_data); end
         end
         cfg_en = (c <= 11);
         if (c == 3) cfg_period = 20'd20;
         his_valid = (c == 8) || (c == 31);
         his_data  = (c == 8) ? 15'h0101 : (c == 31) ? 15'h3C3C : 15'h0000;
      end
      chk("b2b_pulse_count", n_rise, 2);
      chk("b2b_first_pulse", rise_at[0], 2);
      chk("b2b_second_pulse", rise_at[1], 11);
      chk("b2b_new_period_collect", first_ho, 30);
      chk("b2b_frame_valid_count", fv_cnt, 2);
      chk("b2b_second_frame_cycle", first_fv, 32);
      chk("b2b_second_frame_data", cap_data, 'h3C3C);

      // ---------------- back-pressure in OUT ----------------
      cfg_period = 20'd4; cfg_batch = 16'd1; frame_ready = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         cfg_en    = (c == 0);
         his_valid = (c == 5);
         his_data  = 15'h2AAA;
      end
      @(negedge clk);
      his_valid = 1'b0;
      chk("bp_valid_rise", frame_valid, 1);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!frame_valid || frame_data != 15'h2AAA || frame_err || TDC_start || HIS_Oready) bad++;
      end
      chk("bp_stable_50", bad, 0);
      frame_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_drop", frame_valid, 0);

      // ---------------- reset during COLLECT and during FIRE ----------------
      // Busy at c=1 skips the only shot of frame 1 (skip_cnt=1); COLLECT at 5, rst at 7.
      // Restart at 40 -> pulse 42; rst at 43-44; release with cfg_en=1 -> pulse 47.
      cfg_period = 20'd4; cfg_batch = 16'd1;
      n_rise = 0; bad = 0; first_fv = -1; cap_data = 0; prev = 1'b0;
      foreach (rise_at[i]) rise_at[i] = -1;
      for (int c = 0; c <= 60; c++) begin
         @(negedge clk);
         if (TDC_start && !prev) begin
            if (n_rise < 4) rise_at[n_rise] = c;
            n_rise++;
         end
         prev = TDC_start;
         if (c == 6) chk("rst_pre_skip_cnt", skip_cnt, 1);
         if (c == 8)
            chk("rst_collect_outputs",
                {TDC_start, HIS_Oready, frame_valid, frame_err, frame_data, skip_cnt}, 0);
         if (c == 44)
            chk("rst_fire_outputs", {TDC_start, HIS_Oready, frame_valid}, 0);
         if (c >= 8 && c <= 41 && (TDC_start || HIS_Oready || frame_valid)) bad++;
         if (frame_valid && first_fv < 0) begin first_fv = c; cap_data = int'(frame_data); end
         rst       = (c == 7) || (c == 43) || (c == 44);
         cfg_en    = (c <= 7) || (c >= 40 && c <= 45);
         tdc_busy  = (c == 1);
         his_valid = (c == 50);
         his_data  = (c == 50) ? 15'h0F0F : 15'h0000;
      end
      chk("rst_idle_quiet", bad, 0);
      chk("rst_pulse_count", n_rise, 2);
      chk("rst_restart_pulse", rise_at[0], 42);
      chk("rst_release_pulse", rise_at[1], 47);
      chk("rst_after_frame_cycle", first_fv, 51);
      chk("rst_after_frame_data", cap_data, 'h0F0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
